core8_cpu_debug_dispatch: RTL and testbench

CORE8_CPU_DEBUG_DISPATCH -- requirements
Module: core8_cpu_debug_dispatch

---
 rtl/core8_cpu_debug_dispatch_if.sv | 30 +++
 rtl/core8_cpu_debug_dispatch.sv | 150 +++++++++++++++
 tb/tb_core8_cpu_debug_dispatch.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core8_cpu_debug_dispatch_if.sv
// Debug dispatch bus: TCK-side command inputs, per-core acks and dispatch results.
interface core8_cpu_debug_dispatch_if #(
  parameter int unsigned NUM_CORES = 8,
  parameter int unsigned DATA_W    = 38,
  parameter int unsigned IR_W      = 2
);
  logic                 vs_udr;
  logic                 vs_uir;
  logic [IR_W-1:0]      ir_in;
  logic [DATA_W-1:0]    sr;
  logic [3:0]           core_sel;
  logic [NUM_CORES-1:0] core_ack;
  logic [DATA_W-1:0]    jdo;
  logic [IR_W-1:0]      act_ir;
  logic [NUM_CORES-1:0] act_vld;
  logic                 busy;
  logic                 done;
  logic [7:0]           drop_cnt;
  logic                 err_timeout;

  modport master (
    output vs_udr, vs_uir, ir_in, sr, core_sel, core_ack,
    input  jdo, act_ir, act_vld, busy, done, drop_cnt, err_timeout
  );

  modport slave (
    input  vs_udr, vs_uir, ir_in, sr, core_sel, core_ack,
    output jdo, act_ir, act_vld, busy, done, drop_cnt, err_timeout
  );
endinterface

// File: rtl/core8_cpu_debug_dispatch.sv
// Routes virtual-JTAG update-DR commands to one of NUM_CORES debug targets and waits for its ack.
// Optional WAIT timeout is built when CORE8_DBG_DISPATCH_TIMEOUT_EN is defined.
module core8_cpu_debug_dispatch #(
  parameter int unsigned NUM_CORES   = 8,
  parameter int unsigned DATA_W      = 38,
  parameter int unsigned IR_W        = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  core8_cpu_debug_dispatch_if.slave     dbg
);

  localparam int unsigned SEL_SPAN = 16;
  localparam int unsigned TMO_W    = 16;

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_ISSUE, S_WAIT} state_e;

  state_e                state_q, state_d;
  logic [2:0]            udr_sync_q, uir_sync_q;
  logic [DATA_W-1:0]     jdo_q, jdo_d;
  logic [IR_W-1:0]       act_ir_q, act_ir_d;
  logic [3:0]            sel_q, sel_d;
  logic [NUM_CORES-1:0]  act_vld_q, act_vld_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [7:0]            drop_q, drop_d;
  logic                  drop_inc;
  logic                  udr_evt, uir_evt;
  logic                  sel_valid, ack_sel, tmo_hit;
  logic [SEL_SPAN-1:0]   ack_pad, sel_onehot;

  // Rising-edge detect on the synchronized TCK-domain update levels
  assign udr_evt    = udr_sync_q[1] & ~udr_sync_q[2];
  assign uir_evt    = uir_sync_q[1] & ~uir_sync_q[2];
  assign sel_valid  = (32'(sel_q) < NUM_CORES);
  assign ack_pad    = SEL_SPAN'(dbg.core_ack);
  assign ack_sel    = ack_pad[sel_q];
  assign sel_onehot = SEL_SPAN'(1) << sel_q;

  always_ff @(posedge clk) begin : state_reg
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    if (uir_evt) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (udr_evt) state_d = S_CAPT;
        S_CAPT:  state_d = sel_valid ? S_ISSUE : S_IDLE;
        S_ISSUE: state_d = S_WAIT;
        S_WAIT:  if (ack_sel || tmo_hit) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Aborts (uir_evt) suppress captures, strobes, completions and drop counting
  always_comb begin : outputs_next
    jdo_d     = jdo_q;
    act_ir_d  = act_ir_q;
    sel_d     = sel_q;
    act_vld_d = '0;
    done_d    = 1'b0;
    drop_inc  = 1'b0;
    if (!uir_evt) begin
      if (udr_evt && state_q == S_IDLE) begin
        jdo_d    = dbg.sr;
        act_ir_d = dbg.ir_in;
        sel_d    = dbg.core_sel;
      end
      if (udr_evt && state_q != S_IDLE) drop_inc = 1'b1;
      if (state_q == S_CAPT) begin
        if (sel_valid) act_vld_d = sel_onehot[NUM_CORES-1:0];
        else           drop_inc  = 1'b1;
      end
      if (state_q == S_WAIT) done_d = ack_sel;
    end
    drop_d = (drop_inc && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin : out_regs
    if (reset) begin
      udr_sync_q <= '0;
      uir_sync_q <= '0;
      jdo_q      <= '0;
      act_ir_q   <= '0;
      sel_q      <= '0;
      act_vld_q  <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      udr_sync_q <= {udr_sync_q[1:0], dbg.vs_udr};
      uir_sync_q <= {uir_sync_q[1:0], dbg.vs_uir};
      jdo_q      <= jdo_d;
      act_ir_q   <= act_ir_d;
      sel_q      <= sel_d;
      act_vld_q  <= act_vld_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

`ifdef CORE8_DBG_DISPATCH_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  // Fires on the TIMEOUT_CYC-th WAIT cycle without an ack
  assign tmo_hit = (state_q == S_WAIT) && !ack_sel && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin : tmo_next
    tmo_d = tmo_q;
    err_d = err_q;
    if (state_q == S_ISSUE)     tmo_d = '0;
    else if (state_q == S_WAIT) tmo_d = tmo_q + TMO_W'(1);
    if (tmo_hit && !uir_evt)    err_d = 1'b1;
  end

  always_ff @(posedge clk) begin : tmo_regs
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign dbg.err_timeout = err_q;
`else
  logic [TMO_W-1:0] tmo_unused;
  assign tmo_unused      = TMO_W'(TIMEOUT_CYC);
  assign tmo_hit         = 1'b0;
  assign dbg.err_timeout = 1'b0;
`endif

  assign dbg.jdo      = jdo_q;
  assign dbg.act_ir   = act_ir_q;
  assign dbg.act_vld  = act_vld_q;
  assign dbg.busy     = busy_q;
  assign dbg.done     = done_q;
  assign dbg.drop_cnt = drop_q;

endmodule

// File: tb/tb_core8_cpu_debug_dispatch.sv
// Bench for core8_cpu_debug_dispatch: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a command-level reference model.
module tb_core8_cpu_debug_dispatch;
  localparam int unsigned NC = 8;
  localparam int unsigned DW = 38;
  localparam int unsigned IW = 2;
  localparam int unsigned TO = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core8_cpu_debug_dispatch_if #(.NUM_CORES(NC), .DATA_W(DW), .IR_W(IW)) dbg ();

  core8_cpu_debug_dispatch #(
    .NUM_CORES(NC), .DATA_W(DW), .IR_W(IW), .TIMEOUT_CYC(TO)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .dbg   (dbg)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the synchronizer history and one in-flight command by its age
  logic [2:0]    hu, hi;
  bit            active;
  int            age;
  int            waited;
  logic [DW-1:0] m_jdo;
  logic [IW-1:0] m_ir;
  logic [3:0]    m_sel;
  logic [NC-1:0] m_vld;
  bit            m_done;
  bit            m_err;
  int            m_drop;
  bit            ue, ie, inc;
  logic [15:0]   ackp;

  initial begin
    hu = '0; hi = '0; active = 0; age = 0; waited = 0;
    m_jdo = '0; m_ir = '0; m_sel = '0; m_vld = '0; m_done = 0; m_err = 0; m_drop = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      hu = '0; hi = '0; active = 0; age = 0; waited = 0;
      m_jdo = '0; m_ir = '0; m_sel = '0; m_vld = '0; m_done = 0; m_err = 0; m_drop = 0;
    end else begin
      ue = hu[1] && !hu[2];
      ie = hi[1] && !hi[2];
      ackp = 16'(dbg.core_ack);
      m_vld = '0;
      m_done = 0;
      inc = 0;
      if (ie) begin
        active = 0;
      end else if (!active) begin
        if (ue) begin
          m_jdo = dbg.sr; m_ir = dbg.ir_in; m_sel = dbg.core_sel;
          active = 1; age = 0;
        end
      end else begin
        if (ue) inc = 1;
        if (age == 0) begin
          if (int'(m_sel) >= int'(NC)) begin
            active = 0; inc = 1;
          end else begin
            age = 1; m_vld[m_sel[2:0]] = 1'b1;
          end
        end else if (age == 1) begin
          age = 2; waited = 0;
        end else begin
          waited++;
          if (ackp[m_sel]) begin
            m_done = 1; active = 0;
          end
`ifdef CORE8_DBG_DISPATCH_TIMEOUT_EN
          else if (waited == int'(TO)) begin
            m_err = 1; active = 0;
          end
`endif
        end
      end
      if (inc && m_drop < 255) m_drop++;
      hu = {hu[1:0], dbg.vs_udr};
      hi = {hi[1:0], dbg.vs_uir};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("jdo",         64'(dbg.jdo),         64'(m_jdo));
      check("act_ir",      64'(dbg.act_ir),      64'(m_ir));
      check("act_vld",     64'(dbg.act_vld),     64'(m_vld));
      check("busy",        64'(dbg.busy),        64'(active));
      check("done",        64'(dbg.done),        64'(m_done));
      check("drop_cnt",    64'(dbg.drop_cnt),    64'(m_drop));
      check("err_timeout", 64'(dbg.err_timeout), 64'(m_err));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cmd(input logic [3:0] sel, input logic [IW-1:0] ir, input logic [DW-1:0] data);
    dbg.core_sel = sel;
    dbg.ir_in    = ir;
    dbg.sr       = data;
  endtask

  // Pulse vs_udr and return once a valid command has reached WAIT
  task automatic pulse_to_wait(input logic [3:0] sel, input logic [DW-1:0] data);
    set_cmd(sel, 2'd1, data);
    dbg.vs_udr = 1'b1;
    tick(2);
    dbg.vs_udr = 1'b0;
    tick(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int seen;

  initial begin
    reset = 1'b1;
    dbg.vs_udr = 1'b0; dbg.vs_uir = 1'b0; dbg.core_ack = '0;
    set_cmd(4'd0, '0, '0);
    tick(1);
    chk_en = 1'b1;
    tick(2);
    check("rst_jdo",   64'(dbg.jdo), 64'h0);
    check("rst_vld",   64'(dbg.act_vld), 64'h0);
    check("rst_busy",  64'(dbg.busy), 64'h0);
    check("rst_drop",  64'(dbg.drop_cnt), 64'h0);
    check("rst_err",   64'(dbg.err_timeout), 64'h0);
    reset = 1'b0;

    // Basic command to core 5
    set_cmd(4'd5, 2'd2, 38'h2A_DEADBEEF);
    dbg.vs_udr = 1'b1;
    tick(3);
    check("basic_jdo",    64'(dbg.jdo), 64'h2A_DEADBEEF);
    check("basic_ir",     64'(dbg.act_ir), 64'd2);
    check("basic_vld_pre", 64'(dbg.act_vld), 64'h0);
    tick(1);
    check("basic_vld",    64'(dbg.act_vld), 64'h20);
    dbg.vs_udr = 1'b0;
    tick(1);
    check("basic_vld_off", 64'(dbg.act_vld), 64'h0);
    check("basic_busy",   64'(dbg.busy), 64'd1);
    dbg.core_ack = 8'h20;
    tick(1);
    check("basic_done",   64'(dbg.done), 64'd1);
    check("basic_idle",   64'(dbg.busy), 64'd0);
    dbg.core_ack = '0;
    tick(1);
    check("basic_done_off", 64'(dbg.done), 64'd0);

    // Ack from the wrong core is ignored
    pulse_to_wait(4'd2, 38'h01_23456789);
    dbg.core_ack = 8'h01;
    seen = 0;
    repeat (20) begin
      tick(1);
      if (dbg.done) seen++;
    end
    check("wrongack_done", 64'(seen), 64'd0);
    check("wrongack_busy", 64'(dbg.busy), 64'd1);
    dbg.core_ack = 8'h04;
    tick(1);
    check("rightack_done", 64'(dbg.done), 64'd1);
    dbg.core_ack = '0;
    tick(1);

    // Out-of-range select is dropped
    set_cmd(4'd9, 2'd3, 38'h3F_00000001);
    dbg.vs_udr = 1'b1;
    tick(3);
    check("inval_capt_busy", 64'(dbg.busy), 64'd1);
    tick(1);
    check("inval_busy", 64'(dbg.busy), 64'd0);
    check("inval_drop", 64'(dbg.drop_cnt), 64'd1);
    check("inval_vld",  64'(dbg.act_vld), 64'h0);
    dbg.vs_udr = 1'b0;
    tick(2);

    // Overlapping command while waiting is dropped, then aborted by update-IR
    pulse_to_wait(4'd1, 38'h11_11111111);
    set_cmd(4'd3, 2'd0, 38'h22_22222222);
    dbg.vs_udr = 1'b1;
    tick(3);
    dbg.vs_udr = 1'b0;
    tick(2);
    check("ovl_drop", 64'(dbg.drop_cnt), 64'd2);
    check("ovl_jdo",  64'(dbg.jdo), 64'h11_11111111);
    check("ovl_busy", 64'(dbg.busy), 64'd1);
    dbg.vs_uir = 1'b1;
    tick(3);
    check("abort_busy", 64'(dbg.busy), 64'd0);
    check("abort_done", 64'(dbg.done), 64'd0);
    dbg.vs_uir = 1'b0;
    tick(3);

    // Simultaneous update-IR and update-DR: no capture, no count
    set_cmd(4'd4, 2'd2, 38'h33_33333333);
    dbg.vs_udr = 1'b1;
    dbg.vs_uir = 1'b1;
    tick(4);
    check("both_busy", 64'(dbg.busy), 64'd0);
    check("both_drop", 64'(dbg.drop_cnt), 64'd2);
    check("both_jdo",  64'(dbg.jdo), 64'h11_11111111);
    dbg.vs_udr = 1'b0;
    dbg.vs_uir = 1'b0;
    tick(3);

    // No ack at all
    pulse_to_wait(4'd3, 38'h05_55555555);
`ifdef CORE8_DBG_DISPATCH_TIMEOUT_EN
    seen = 0;
    repeat (12) begin
      tick(1);
      if (dbg.done) seen++;
    end
    check("tmo_err",  64'(dbg.err_timeout), 64'd1);
    check("tmo_busy", 64'(dbg.busy), 64'd0);
    check("tmo_done", 64'(seen), 64'd0);
`else
    tick(1000);
    check("hang_busy", 64'(dbg.busy), 64'd1);
    check("hang_err",  64'(dbg.err_timeout), 64'd0);
    dbg.vs_uir = 1'b1;
    tick(3);
    dbg.vs_uir = 1'b0;
    tick(3);
`endif

    // Drop counter saturation
    set_cmd(4'd9, 2'd0, 38'h0);
    repeat (300) begin
      dbg.vs_udr = 1'b1;
      tick(2);
      dbg.vs_udr = 1'b0;
      tick(3);
    end
    check("sat_drop", 64'(dbg.drop_cnt), 64'd255);

    // Reset in the middle of a command
    set_cmd(4'd6, 2'd1, 38'h06_66666666);
    dbg.vs_udr = 1'b1;
    tick(4);
    check("mid_vld", 64'(dbg.act_vld), 64'h40);
    dbg.vs_udr = 1'b0;
    reset = 1'b1;
    tick(1);
    check("mid_rst_vld",  64'(dbg.act_vld), 64'h0);
    check("mid_rst_busy", 64'(dbg.busy), 64'd0);
    check("mid_rst_drop", 64'(dbg.drop_cnt), 64'd0);
    check("mid_rst_err",  64'(dbg.err_timeout), 64'd0);
    reset = 1'b0;
    tick(2);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0)  dbg.vs_udr = ~dbg.vs_udr;
      if ($urandom_range(0, 39) == 0) dbg.vs_uir = ~dbg.vs_uir;
      if (!dbg.vs_udr)
        set_cmd(4'($urandom_range(0, 11)), IW'($urandom), DW'({$urandom, $urandom}));
      dbg.core_ack = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '0;
      reset = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    reset = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
